store_buffer_pq: RTL and testbench

//  Parametrised successor store buffer for the memory stage: circular FIFO of DEPTH stores held until ROB commit.

---
 rtl/store_buffer_pq.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_store_buffer_pq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_pq.sv
// ---------------------------------------------------------------------------
// store_buffer_pq
//
// Purpose
//   Store buffer for the memory stage. It is a circular FIFO of DEPTH stores
//   that are held until the ROB commits them. Committed stores drain
//   oldest-first into the D-cache through a valid/ready handshake. Loads look
//   up the buffered stores byte by byte, and the youngest writer of each byte
//   wins. A load that is only partly covered by buffered stores stalls until
//   the overlapping store has drained. An exception reported with a commit
//   flushes every uncommitted store. Committed stores survive the flush.
//
// Parameters
//   DEPTH      number of entries (power of 2, >= 2)
//   ADDR_W     byte address width
//   ROB_IDX_W  ROB tag width
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   in_store_instr      allocate a store this cycle
//   in_load_instr       load lookup this cycle
//   in_addr             store/load byte address
//   in_data             store data, LSB-aligned
//   in_funct3           RISC-V funct3 (SB/SH/SW, LB/LH/LW/LBU/LHU)
//   in_rob_idx          ROB tag of the allocating store
//   in_complete         ROB commit strobe
//   in_complete_idx     ROB tag being committed
//   in_exception_vector non-zero together with in_complete: flush
//   in_cache_ready      cache accepts the drain write this cycle
//   out_write_to_cache  drain request valid
//   out_addr            drain byte address
//   out_data            drain data, or the forwarded load value during a load
//   out_funct3          drain store width
//   out_hit             load fully forwarded from the buffer
//   out_stall           store into a full buffer, or a load that must wait
//   out_count           number of occupied entries
//
// Configuration
//   SB_FORWARD_EN  defined:   loads are forwarded byte-granularly (out_hit).
//                  undefined: out_hit is tied to 0, and any byte overlap with
//                             a buffered store stalls the load until the
//                             overlapping entries have drained.
// ---------------------------------------------------------------------------
module store_buffer_pq #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 32,
    parameter int ROB_IDX_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_store_instr,
    input  logic                  in_load_instr,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [31:0]           in_data,
    input  logic [2:0]            in_funct3,
    input  logic [ROB_IDX_W-1:0]  in_rob_idx,
    input  logic                  in_complete,
    input  logic [ROB_IDX_W-1:0]  in_complete_idx,
    input  logic [2:0]            in_exception_vector,
    input  logic                  in_cache_ready,
    output logic                  out_write_to_cache,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [31:0]           out_data,
    output logic [2:0]            out_funct3,
    output logic                  out_hit,
    output logic                  out_stall,
    output logic [$clog2(DEPTH):0] out_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } drain_state_e;

    // Byte lanes touched by an access of the given width at the given offset.
    function automatic logic [3:0] byte_mask(input logic [2:0] funct3,
                                             input logic [1:0] offset);
        logic [3:0] m;
        case (funct3[1:0])
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m << offset;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    drain_state_e          state_q, state_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      committed_q, committed_d;

    logic [ADDR_W-1:0]     addr_q   [DEPTH];
    logic [ADDR_W-1:0]     addr_d   [DEPTH];
    logic [31:0]           data_q   [DEPTH];
    logic [31:0]           data_d   [DEPTH];
    logic [3:0]            mask_q   [DEPTH];
    logic [3:0]            mask_d   [DEPTH];
    logic [2:0]            funct3_q [DEPTH];
    logic [2:0]            funct3_d [DEPTH];
    logic [ROB_IDX_W-1:0]  rob_q    [DEPTH];
    logic [ROB_IDX_W-1:0]  rob_d    [DEPTH];

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic             full;
    logic             commit_en;
    logic             flush_en;
    logic             alloc;
    logic             pop;
    logic             in_req;
    logic [PTR_W-1:0] age_idx [DEPTH];
    logic [CNT_W-1:0] keep_len;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign commit_en = in_complete && (in_exception_vector == 3'b000);
    assign flush_en  = in_complete && (in_exception_vector != 3'b000);
    assign in_req    = (state_q == S_REQ);
    assign pop       = in_req && in_cache_ready;
    // A store that arrives in the same cycle as a flush is dropped.
    assign alloc     = in_store_instr && !full && !flush_en;

    // age_idx[0] is the oldest slot and age_idx[DEPTH-1] the youngest.
    always_comb begin
        for (int o = 0; o < DEPTH; o++) begin
            age_idx[o] = head_q + PTR_W'(o);
        end
    end

    // Committed entries form a contiguous run from the head because the ROB
    // commits in order. The flush keeps this run and rewinds the tail to the
    // slot just after its youngest member.
    always_comb begin
        keep_len = '0;
        for (int o = 0; o < DEPTH; o++) begin
            if (valid_q[age_idx[o]] && committed_q[age_idx[o]]) begin
                keep_len = CNT_W'(o + 1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (valid_q[head_q] && committed_q[head_q]) state_d = S_REQ;
            S_REQ:   if (in_cache_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Queue next state: commit, pop, flush, allocate
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d starts as a copy of its _q, so paths that do not
        // touch a signal hold it instead of inferring a latch.
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        valid_d     = valid_q;
        committed_d = committed_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mask_d      = mask_q;
        funct3_d    = funct3_q;
        rob_d       = rob_q;

        if (commit_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (rob_q[i] == in_complete_idx)) begin
                    committed_d[i] = 1'b1;
                end
            end
        end

        // The head in REQ is committed, so a flush can never remove it.
        if (pop) begin
            valid_d[head_q]     = 1'b0;
            committed_d[head_q] = 1'b0;
            head_d              = head_q + PTR_W'(1);
        end

        if (flush_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!committed_q[i]) begin
                    valid_d[i] = 1'b0;
                end
            end
            tail_d  = head_q + keep_len[PTR_W-1:0];
            count_d = keep_len - CNT_W'(pop);
        end else begin
            if (alloc) begin
                valid_d[tail_q]     = 1'b1;
                committed_d[tail_q] = 1'b0;
                addr_d[tail_q]      = in_addr;
                data_d[tail_q]      = in_data;
                mask_d[tail_q]      = byte_mask(in_funct3, in_addr[1:0]);
                funct3_d[tail_q]    = in_funct3;
                rob_d[tail_q]       = in_rob_idx;
                tail_d              = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Load lookup: which bytes of the load are covered by buffered stores
    // ------------------------------------------------------------------
    logic [3:0] load_mask;
    logic [3:0] byte_cov;
    logic       overlap;
    logic       load_stall;

    always_comb begin
        load_mask = byte_mask(in_funct3, in_addr[1:0]);
        byte_cov  = '0;
        for (int o = 0; o < DEPTH; o++) begin
            if (valid_q[age_idx[o]] &&
                (addr_q[age_idx[o]][ADDR_W-1:2] == in_addr[ADDR_W-1:2])) begin
                byte_cov = byte_cov | mask_q[age_idx[o]];
            end
        end
    end

    assign overlap = |(byte_cov & load_mask);

    // ------------------------------------------------------------------
    // Drain outputs: the head entry while in REQ, 0 otherwise
    // ------------------------------------------------------------------
    logic [31:0] drain_data;

    assign out_write_to_cache = in_req;
    assign out_addr           = in_req ? addr_q[head_q]   : '0;
    assign out_funct3         = in_req ? funct3_q[head_q] : '0;
    assign drain_data         = in_req ? data_q[head_q]   : '0;

`ifdef SB_FORWARD_EN
    logic        all_cov;
    logic        load_hit;
    logic [31:0] fwd_lane;
    logic [31:0] fwd_word;
    logic [31:0] fwd_shift;
    logic [31:0] fwd_data;

    assign all_cov = ((byte_cov & load_mask) == load_mask);

    // Scan oldest to youngest, so a younger writer overwrites each byte it
    // covers. Stored data is LSB-aligned and is moved into its byte lanes here.
    always_comb begin
        fwd_lane = '0;
        fwd_word = '0;
        for (int o = 0; o < DEPTH; o++) begin
            if (valid_q[age_idx[o]] &&
                (addr_q[age_idx[o]][ADDR_W-1:2] == in_addr[ADDR_W-1:2])) begin
                fwd_lane = data_q[age_idx[o]] << {addr_q[age_idx[o]][1:0], 3'b000};
                for (int b = 0; b < 4; b++) begin
                    if (mask_q[age_idx[o]][b]) begin
                        fwd_word[8*b +: 8] = fwd_lane[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        fwd_shift = fwd_word >> {in_addr[1:0], 3'b000};
        case (in_funct3)
            3'b000:  fwd_data = {{24{fwd_shift[7]}},  fwd_shift[7:0]};
            3'b001:  fwd_data = {{16{fwd_shift[15]}}, fwd_shift[15:0]};
            3'b100:  fwd_data = {24'h0, fwd_shift[7:0]};
            3'b101:  fwd_data = {16'h0, fwd_shift[15:0]};
            default: fwd_data = fwd_shift;
        endcase
    end

    assign load_hit   = in_load_instr && all_cov;
    assign load_stall = in_load_instr && overlap && !all_cov;
    assign out_hit    = load_hit;
    assign out_data   = in_load_instr ? (load_hit ? fwd_data : 32'h0) : drain_data;
`else
    // Without forwarding, any overlap waits for the store to reach the cache.
    assign load_stall = in_load_instr && overlap;
    assign out_hit    = 1'b0;
    assign out_data   = drain_data;
`endif

    assign out_stall = (in_store_instr && full) || load_stall;
    assign out_count = count_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // flop samples the pre-edge value of its _d regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            committed_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            committed_q <= committed_d;
        end
    end

    // NOTE: the entry payload has no reset. valid_q qualifies every read of
    // it, so stale contents are never observed.
    always_ff @(posedge clk) begin
        addr_q   <= addr_d;
        data_q   <= data_d;
        mask_q   <= mask_d;
        funct3_q <= funct3_d;
        rob_q    <= rob_d;
    end

endmodule

// File: tb/tb_store_buffer_pq.sv
// ---------------------------------------------------------------------------
// tb_store_buffer_pq
//
// Self-checking bench for store_buffer_pq (DEPTH=4, ADDR_W=32, ROB_IDX_W=4).
// Each committed store pushes its expected cache write onto a queue. A
// negedge monitor pops the queue and compares it whenever a drain handshake
// is about to complete. Load lookups and status outputs are checked directly
// against values the bench computes itself. Expectations follow
// SB_FORWARD_EN in the same way the design does.
// ---------------------------------------------------------------------------
module tb_store_buffer_pq;

    localparam int DEPTH     = 4;
    localparam int ADDR_W    = 32;
    localparam int ROB_IDX_W = 4;
    localparam int CNT_W     = $clog2(DEPTH) + 1;
`ifdef SB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                  clk;
    logic                  reset;
    logic                  in_store_instr;
    logic                  in_load_instr;
    logic [ADDR_W-1:0]     in_addr;
    logic [31:0]           in_data;
    logic [2:0]            in_funct3;
    logic [ROB_IDX_W-1:0]  in_rob_idx;
    logic                  in_complete;
    logic [ROB_IDX_W-1:0]  in_complete_idx;
    logic [2:0]            in_exception_vector;
    logic                  in_cache_ready;
    logic                  out_write_to_cache;
    logic [ADDR_W-1:0]     out_addr;
    logic [31:0]           out_data;
    logic [2:0]            out_funct3;
    logic                  out_hit;
    logic                  out_stall;
    logic [CNT_W-1:0]      out_count;

    store_buffer_pq #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .ROB_IDX_W (ROB_IDX_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_store_instr      (in_store_instr),
        .in_load_instr       (in_load_instr),
        .in_addr             (in_addr),
        .in_data             (in_data),
        .in_funct3           (in_funct3),
        .in_rob_idx          (in_rob_idx),
        .in_complete         (in_complete),
        .in_complete_idx     (in_complete_idx),
        .in_exception_vector (in_exception_vector),
        .in_cache_ready      (in_cache_ready),
        .out_write_to_cache  (out_write_to_cache),
        .out_addr            (out_addr),
        .out_data            (out_data),
        .out_funct3          (out_funct3),
        .out_hit             (out_hit),
        .out_stall           (out_stall),
        .out_count           (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  funct3;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_w;
    int  vectors     = 0;
    int  miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic wr_t mk_wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        wr_t w;
        w.addr   = a;
        w.data   = d;
        w.funct3 = f3;
        return w;
    endfunction

    // Drain monitor: the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (reset && out_write_to_cache && in_cache_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_w = exp_q.pop_front();
                check("drain_addr", out_addr, mon_w.addr);
                check("drain_data", out_data, mon_w.data);
                check("drain_f3", out_funct3, mon_w.funct3);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] f3, input logic [3:0] tag);
        in_store_instr = 1'b1;
        in_addr        = a;
        in_data        = d;
        in_funct3      = f3;
        in_rob_idx     = tag;
        tick();
        in_store_instr = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] tag, input bit push, input wr_t w);
        in_complete         = 1'b1;
        in_complete_idx     = tag;
        in_exception_vector = 3'b000;
        if (push) exp_q.push_back(w);
        tick();
        in_complete = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic e_hit, input logic e_stall,
                         input logic chk_data, input logic [31:0] e_data);
        in_load_instr = 1'b1;
        in_addr       = a;
        in_funct3     = f3;
        #1;
        check({tag, "_hit"}, out_hit, e_hit);
        check({tag, "_stall"}, out_stall, e_stall);
        if (chk_data) check({tag, "_data"}, out_data, e_data);
        in_load_instr = 1'b0;
        tick();
    endtask

    task automatic wait_write(input string tag);
        for (int n = 0; n < 20 && !out_write_to_cache; n++) tick();
        check(tag, out_write_to_cache, 1'b1);
    endtask

    task automatic wait_empty(input string tag);
        for (int n = 0; n < 60 && (out_count != 0 || out_write_to_cache); n++) tick();
        check({tag, "_count"}, out_count, 0);
        check({tag, "_write"}, out_write_to_cache, 1'b0);
    endtask

    initial begin
        reset               = 1'b0;
        in_store_instr      = 1'b0;
        in_load_instr       = 1'b0;
        in_addr             = '0;
        in_data             = '0;
        in_funct3           = '0;
        in_rob_idx          = '0;
        in_complete         = 1'b0;
        in_complete_idx     = '0;
        in_exception_vector = '0;
        in_cache_ready      = 1'b0;

        // Reset state
        #2;
        check("rst_write", out_write_to_cache, 1'b0);
        check("rst_count", out_count, 0);
        check("rst_stall", out_stall, 1'b0);
        check("rst_hit", out_hit, 1'b0);
        check("rst_data", out_data, 32'h0);
        check("rst_addr", out_addr, 32'h0);
        check("rst_f3", out_funct3, 3'b000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // 1: SW then LW of the same word, nothing is written before commit
        in_store_instr = 1'b1; in_addr = 32'h100; in_data = 32'hDEAD_BEEF;
        in_funct3 = 3'b010; in_rob_idx = 4'd3;
        #1 check("t1_store_stall", out_stall, 1'b0);
        tick();
        in_store_instr = 1'b0;
        check("t1_count", out_count, 1);
        probe("t1_lw", 32'h100, 3'b010, FWD, !FWD, FWD, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            check("t1_no_write", out_write_to_cache, 1'b0);
            tick();
        end

        // 2: commit, one REQ cycle with ready=1, count 1 -> 0
        in_cache_ready = 1'b1;
        do_commit(4'd3, 1'b1, mk_wr(32'h100, 32'hDEAD_BEEF, 3'b010));
        check("t2_idle_after_commit", out_write_to_cache, 1'b0);
        tick();
        check("t2_req", out_write_to_cache, 1'b1);
        check("t2_count_req", out_count, 1);
        tick();
        check("t2_count_done", out_count, 0);
        check("t2_write_done", out_write_to_cache, 1'b0);

        // 6: REQ outputs held stable while the cache is not ready
        in_cache_ready = 1'b0;
        do_store(32'h200, 32'h1234_5678, 3'b010, 4'd5);
        do_commit(4'd5, 1'b1, mk_wr(32'h200, 32'h1234_5678, 3'b010));
        wait_write("t6_req_seen");
        for (int k = 0; k < 3; k++) begin
            check("t6_req_write", out_write_to_cache, 1'b1);
            check("t6_req_addr", out_addr, 32'h200);
            check("t6_req_data", out_data, 32'h1234_5678);
            check("t6_req_f3", out_funct3, 3'b010);
            probe("t6_lw_in_req", 32'h200, 3'b010, FWD, !FWD, 1'b1, 32'h1234_5678);
        end
        in_cache_ready = 1'b1;
        wait_empty("t6_drained");
        probe("t6_lw_after", 32'h200, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);

        // 3: byte store, sign/zero extension, partial overlap, word mismatch
        in_cache_ready = 1'b0;
        do_store(32'h101, 32'h0000_0080, 3'b000, 4'd6);
        probe("t3_lb", 32'h101, 3'b000, FWD, !FWD, FWD, 32'hFFFF_FF80);
        probe("t3_lbu", 32'h101, 3'b100, FWD, !FWD, FWD, 32'h0000_0080);
        probe("t3_lw_partial", 32'h100, 3'b010, 1'b0, 1'b1, 1'b0, 32'h0);
        probe("t3_lb_other_byte", 32'h102, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        probe("t3_lb_other_word", 32'h105, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        do_store(32'h102, 32'h0000_BEEF, 3'b001, 4'd7);
        probe("t3_lh", 32'h102, 3'b001, FWD, !FWD, FWD, 32'hFFFF_BEEF);
        probe("t3_lw_partial2", 32'h100, 3'b010, 1'b0, 1'b1, 1'b0, 32'h0);
        do_store(32'h103, 32'h0000_0011, 3'b000, 4'd8);
        probe("t3_lhu_youngest", 32'h102, 3'b101, FWD, !FWD, FWD, 32'h0000_11EF);
        in_cache_ready = 1'b1;
        do_commit(4'd6, 1'b1, mk_wr(32'h101, 32'h0000_0080, 3'b000));
        do_commit(4'd7, 1'b1, mk_wr(32'h102, 32'h0000_BEEF, 3'b001));
        do_commit(4'd8, 1'b1, mk_wr(32'h103, 32'h0000_0011, 3'b000));
        wait_empty("t3_drained");

        // 4: fifth store into a full buffer stalls until an entry drains
        in_cache_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h400 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010, 4'(9 + i));
        end
        check("t4_count_full", out_count, 4);
        in_store_instr = 1'b1; in_addr = 32'h410; in_data = 32'hA4;
        in_funct3 = 3'b010; in_rob_idx = 4'd13;
        #1 check("t4_stall_full", out_stall, 1'b1);
        tick();
        check("t4_count_held", out_count, 4);
        check("t4_stall_held", out_stall, 1'b1);
        in_cache_ready = 1'b1;
        do_commit(4'd9, 1'b1, mk_wr(32'h400, 32'hA0, 3'b010));
        in_store_instr = 1'b1;
        for (int n = 0; n < 20 && out_stall; n++) tick();
        check("t4_stall_release", out_stall, 1'b0);
        tick();
        in_store_instr = 1'b0;
        check("t4_count_after_wrap", out_count, 4);
        for (int i = 1; i < 5; i++) begin
            do_commit(4'(9 + i), 1'b1, mk_wr(32'h400 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010));
        end
        wait_empty("t4_drained");

        // 5: exception flush keeps only the committed store
        in_cache_ready = 1'b0;
        do_store(32'h500, 32'h5000_0001, 3'b010, 4'd1);
        do_store(32'h504, 32'h5000_0002, 3'b010, 4'd2);
        do_store(32'h508, 32'h5000_0003, 3'b010, 4'd3);
        do_commit(4'd1, 1'b1, mk_wr(32'h500, 32'h5000_0001, 3'b010));
        in_complete = 1'b1; in_complete_idx = 4'd2; in_exception_vector = 3'b010;
        in_store_instr = 1'b1; in_addr = 32'h50C; in_data = 32'h5000_0004;
        in_funct3 = 3'b010; in_rob_idx = 4'd4;
        tick();
        in_complete = 1'b0; in_exception_vector = 3'b000; in_store_instr = 1'b0;
        check("t5_count_after_flush", out_count, 1);
        probe("t5_lw_flushed", 32'h504, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
        probe("t5_lw_dropped", 32'h50C, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
        probe("t5_lw_kept", 32'h500, 3'b010, FWD, !FWD, 1'b1, 32'h5000_0001);
        in_cache_ready = 1'b1;
        wait_empty("t5_drained");

        // Reset during REQ: the write never completes and the store is lost
        in_cache_ready = 1'b0;
        do_store(32'h600, 32'h0000_0055, 3'b010, 4'd6);
        do_commit(4'd6, 1'b0, mk_wr(32'h600, 32'h0000_0055, 3'b010));
        wait_write("rst_mid_req_seen");
        reset = 1'b0;
        #1;
        check("rst_mid_write", out_write_to_cache, 1'b0);
        check("rst_mid_count", out_count, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        in_cache_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_mid_lost", {out_write_to_cache, out_count}, {1'b0, CNT_W'(0)});
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
